apb_master_arbiter: RTL and testbench
=====================================

# apb_master_arbiter

Sequencer and round-robin arbiter that shares one APB master port among NB_REQ requesters using a simple req/gnt/rvalid protocol. It turns each granted request into a standard two-phase APB transfer (SETUP, then ACCESS) and returns read data and the error status to the owning requester. It sits between the core-side/debug-side bus adapters and the peripheral APB interconnect (UART, GPIO, SPI, timer, event unit, I2C, FLL, SoC control).

## Interface
- NB_REQ, 2, number of requesters (1..8)
- APB_ADDR_WIDTH, 32, APB address width
- APB_DATA_WIDTH, 32, APB data width
- TIMEOUT_CYCLES, 256, ACCESS-phase watchdog limit (used only when `APB_ARB_TIMEOUT_EN` is defined); must be 2 or more
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- req_i  in  NB_REQ  per-requester request; held high until gnt
- we_i  in  NB_REQ  1 = write
- addr_i  in  NB_REQ*APB_ADDR_WIDTH  packed per-requester address (requester i at slice i)
- wdata_i  in  NB_REQ*APB_DATA_WIDTH  packed per-requester write data
- gnt_o  out  NB_REQ  one-hot grant, single-cycle
- rvalid_o  out  NB_REQ  one-hot response-valid, single-cycle pulse
- rdata_o  out  APB_DATA_WIDTH  read data; meaningful only with rvalid_o
- err_o  out  1  transfer error; meaningful only with rvalid_o
- paddr, pwdata  out  APB_ADDR_WIDTH / APB_DATA_WIDTH  APB master address and write data
- pwrite, psel, penable  out  1  APB master controls
- prdata  in  APB_DATA_WIDTH; pready, pslverr  in  1  APB slave response

## Operation
- The FSM has three states: IDLE, SETUP and ACCESS.
- IDLE:
  - If any req_i is high, the arbiter picks a winner by round-robin.
  - gnt_o[winner] is asserted combinationally in the same cycle.
  - addr, we and wdata of the winner are registered, along with the owner index.
  - Next state is SETUP.
  - With no request, the FSM stays in IDLE.
- SETUP: psel=1, penable=0. Next state is ACCESS unconditionally.
- ACCESS: psel=1, penable=1.
  - On pready=1, the block captures prdata (reads only; writes return 0) and pslverr, then returns to IDLE.
  - The next cycle it drives rvalid_o[owner]=1, rdata_o and err_o.
- Round-robin rule:
  - The priority pointer equals last winner + 1 (mod NB_REQ).
  - The pointer updates only on a grant.
  - Reset pointer is NB_REQ-1, so requester 0 wins first.
- Requesters must hold req_i, we_i, addr_i and wdata_i stable until gnt. Dropping req_i before gnt withdraws the request with no side effects.
- Simultaneous events:
  - A requester may assert req_i in the same cycle its rvalid_o is asserted. That cycle is IDLE, so it may be granted immediately (back-to-back operation).
  - pready=1 in SETUP is ignored.
- While not in SETUP or ACCESS: psel=0, penable=0, and paddr/pwdata/pwrite hold their last values.

## Timing
- Reset value of every output is 0: gnt_o, rvalid_o, rdata_o, err_o, paddr, pwdata, pwrite, psel, penable. The FSM resets to IDLE.
- Latency:
  - req/gnt in cycle T.
  - SETUP in T+1.
  - ACCESS from T+2.
  - With pready=1 at T+2, rvalid_o is asserted at T+3, and the next grant is possible at T+3.
- Minimum throughput is one transfer per 3 cycles. Each extra wait state adds one cycle.
- Reset asserted mid-transfer forces psel and penable to 0 asynchronously. The transfer is dropped, no rvalid_o is issued, and the pointer reverts to NB_REQ-1.
- The APB_ADDR_WIDTH and APB_DATA_WIDTH fields pass through unchanged, with no width conversion.

## Configuration
- `APB_ARB_TIMEOUT_EN` defined:
  - An ACCESS-cycle counter (width $clog2(TIMEOUT_CYCLES+1)) is cleared on entering ACCESS and counts each ACCESS cycle with pready=0.
  - When it reaches TIMEOUT_CYCLES, the FSM leaves ACCESS with psel/penable dropped, and the next cycle it issues rvalid_o[owner] with err_o=1 and rdata_o=0.
  - If pready arrives in the same cycle as the limit, pready wins and the response is normal.
- `APB_ARB_TIMEOUT_EN` undefined: no counter is built, and ACCESS waits for pready indefinitely.

## Structure
- Package apb_arbiter_pkg holds:
  - the state enum (IDLE, SETUP, ACCESS)
  - the default TIMEOUT_CYCLES constant
  - a function computing the owner index width ($clog2 of NB_REQ, minimum 1)
- Sub-module apb_rr_prio: combinational round-robin winner select from req vector and pointer. It outputs a one-hot grant and the index, and is reused for the pointer update.

## Test plan
- Single read: req_i=01, addr 0x1A10_1000, slave pready at first ACCESS with prdata 0xCAFE_0001 -> gnt_o=01 at T, psel T+1..T+2, penable T+2, rvalid_o=01 with rdata_o=0xCAFE_0001 and err_o=0 at T+3.
- Contention: req_i=11 held continuously, four transfers -> grant order 0,1,0,1; each write carries the correct requester's wdata to pwdata.
- Wait states plus error: slave holds pready=0 for 5 ACCESS cycles and then returns pready=1 with pslverr=1 -> penable is high for 6 cycles and rvalid is asserted with err_o=1.
- Back-to-back: requester 1 re-asserts req in its rvalid cycle -> gnt in that same cycle, SETUP the next cycle, and no idle gap.
- Timeout (macro defined, TIMEOUT_CYCLES=8): pready is never asserted -> psel drops after 8 ACCESS cycles, then rvalid is asserted with err_o=1 and rdata_o=0. Without the macro, psel stays high for 1000 cycles.
- Reset during ACCESS: assert rst -> psel/penable are 0 in the same cycle, no rvalid follows, and the first grant after reset goes to requester 0 with req_i=11.

Source files
------------

// File: rtl/apb_arbiter_pkg.sv
// Shared types and helpers for the APB master arbiter.
// Purely declarative: no logic and no latency.
package apb_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 256;

  // A single requester still needs a 1-bit owner index.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/apb_rr_prio.sv
// Round-robin pick: scans req_i starting just after ptr_i (the last winner), wrapping.
// Combinational, zero latency; no backpressure, the caller decides when a grant is consumed.
module apb_rr_prio #(
  parameter int unsigned NB_REQ = 2,
  parameter int unsigned IW     = 1
) (
  input  logic [NB_REQ-1:0] req_i,
  input  logic [IW-1:0]     ptr_i,
  output logic [NB_REQ-1:0] gnt_o,
  output logic [IW-1:0]     idx_o,
  output logic              any_o
);

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int unsigned k = 1; k <= NB_REQ; k++) begin
      if (!any_o && req_i[(32'(ptr_i) + k) % NB_REQ]) begin
        any_o = 1'b1;
        gnt_o[(32'(ptr_i) + k) % NB_REQ] = 1'b1;
        idx_o = IW'((32'(ptr_i) + k) % NB_REQ);
      end
    end
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// Shares one APB master among NB_REQ req/gnt/rvalid requesters; gnt at T, SETUP T+1, ACCESS T+2..,
// rvalid the cycle after pready; requesters hold req until gnt. APB_ARB_TIMEOUT_EN adds an ACCESS watchdog.
module apb_master_arbiter
  import apb_arbiter_pkg::*;
#(
  parameter int unsigned NB_REQ         = 2,
  parameter int unsigned APB_ADDR_WIDTH = 32,
  parameter int unsigned APB_DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NB_REQ-1:0]                req_i,
  input  logic [NB_REQ-1:0]                we_i,
  input  logic [NB_REQ*APB_ADDR_WIDTH-1:0] addr_i,
  input  logic [NB_REQ*APB_DATA_WIDTH-1:0] wdata_i,
  output logic [NB_REQ-1:0]                gnt_o,
  output logic [NB_REQ-1:0]                rvalid_o,
  output logic [APB_DATA_WIDTH-1:0]        rdata_o,
  output logic                             err_o,
  output logic [APB_ADDR_WIDTH-1:0]        paddr,
  output logic [APB_DATA_WIDTH-1:0]        pwdata,
  output logic                             pwrite,
  output logic                             psel,
  output logic                             penable,
  input  logic [APB_DATA_WIDTH-1:0]        prdata,
  input  logic                             pready,
  input  logic                             pslverr
);

  localparam int unsigned IW = idx_width(NB_REQ);

  state_e                    state_q, state_d;
  logic [IW-1:0]             last_q, last_d;
  logic [IW-1:0]             own_q, own_d;
  logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [APB_DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                      pwrite_q, pwrite_d;
  logic                      psel_q, psel_d;
  logic                      penable_q, penable_d;
  logic [NB_REQ-1:0]         rvalid_q, rvalid_d;
  logic [APB_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                      err_q, err_d;
  logic                      timeout;

  logic [NB_REQ-1:0] rr_gnt;
  logic [IW-1:0]     rr_idx;
  logic              rr_any;

  apb_rr_prio #(.NB_REQ(NB_REQ), .IW(IW)) u_rr (
    .req_i (req_i),
    .ptr_i (last_q),
    .gnt_o (rr_gnt),
    .idx_o (rr_idx),
    .any_o (rr_any)
  );

`ifdef APB_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  // cnt_q counts earlier stalled ACCESS cycles; this stalled cycle is the one that hits the limit.
  assign timeout = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  // Grant is combinational in IDLE and masked while reset is held.
  assign gnt_o = (state_q == IDLE && !rst) ? rr_gnt : '0;

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    own_d     = own_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    pwrite_d  = pwrite_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    rvalid_d  = '0;
    rdata_d   = rdata_q;
    err_d     = err_q;
`ifdef APB_ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (rr_any) begin
          state_d  = SETUP;
          last_d   = rr_idx;
          own_d    = rr_idx;
          paddr_d  = addr_i[32'(rr_idx)*APB_ADDR_WIDTH +: APB_ADDR_WIDTH];
          pwdata_d = wdata_i[32'(rr_idx)*APB_DATA_WIDTH +: APB_DATA_WIDTH];
          pwrite_d = we_i[rr_idx];
          psel_d   = 1'b1;
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
`ifdef APB_ARB_TIMEOUT_EN
        cnt_d     = '0;
`endif
      end
      ACCESS: begin
        if (pready) begin
          state_d          = IDLE;
          psel_d           = 1'b0;
          penable_d        = 1'b0;
          rvalid_d[own_q]  = 1'b1;
          rdata_d          = pwrite_q ? '0 : prdata;
          err_d            = pslverr;
        end else if (timeout) begin
          state_d          = IDLE;
          psel_d           = 1'b0;
          penable_d        = 1'b0;
          rvalid_d[own_q]  = 1'b1;
          rdata_d          = '0;
          err_d            = 1'b1;
        end
`ifdef APB_ARB_TIMEOUT_EN
        else begin
          cnt_d = cnt_q + CW'(1);
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      last_q    <= IW'(NB_REQ - 1);
      own_q     <= '0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pwrite_q  <= 1'b0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      rvalid_q  <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      own_q     <= own_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      pwrite_q  <= pwrite_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
`ifdef APB_ARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  assign err_o    = err_q;
  assign paddr    = paddr_q;
  assign pwdata   = pwdata_q;
  assign pwrite   = pwrite_q;
  assign psel     = psel_q;
  assign penable  = penable_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Bench for apb_master_arbiter: transaction-level model (age since grant) checked every cycle,
// directed scenarios with literal expectations, then randomized requesters and slave.
module tb_apb_master_arbiter;
  localparam int NB = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [NB-1:0]     req_i, we_i;
  logic [NB*AW-1:0]  addr_i;
  logic [NB*DW-1:0]  wdata_i;
  logic [NB-1:0]     gnt_o, rvalid_o;
  logic [DW-1:0]     rdata_o;
  logic              err_o;
  logic [AW-1:0]     paddr;
  logic [DW-1:0]     pwdata;
  logic              pwrite, psel, penable;
  logic [DW-1:0]     prdata;
  logic              pready, pslverr;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  apb_master_arbiter #(
    .NB_REQ(NB), .APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .we_i(we_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o),
    .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite), .psel(psel), .penable(penable),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  // Model: a transfer is described by its age in cycles since its grant (grant cycle = 0).
  bit            busy;
  int            age, owner, last_win;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic          m_we;
  bit            rv_pend;
  int            rv_owner;
  logic [DW-1:0] rv_data;
  logic          rv_err;
  logic [NB-1:0] m_gnt;
  logic [NB-1:0] one = 1;

  logic [NB-1:0] s_gnt, s_rv;
  logic          s_psel, s_pen, s_err;
  logic [DW-1:0] s_rdata, s_pwdata;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int rr_pick(input logic [NB-1:0] r, input int last);
    for (int k = 1; k <= NB; k++)
      if (r[(last + k) % NB]) return (last + k) % NB;
    return -1;
  endfunction

  task automatic model_reset();
    busy = 0; age = 0; owner = 0; last_win = NB - 1;
    m_addr = '0; m_wdata = '0; m_we = 1'b0;
    rv_pend = 0; rv_owner = 0; rv_data = '0; rv_err = 1'b0; m_gnt = '0;
  endtask

  // Called at a negedge with inputs already driven: compare, advance the model, go to the next negedge.
  task automatic tick();
    int w;
    logic [NB-1:0] eg;
    #1;
    w  = busy ? -1 : rr_pick(req_i, last_win);
    eg = (w >= 0) ? (one << w) : '0;
    m_gnt = eg;
    s_gnt = gnt_o; s_rv = rvalid_o; s_psel = psel; s_pen = penable;
    s_err = err_o; s_rdata = rdata_o; s_pwdata = pwdata;
    chk("gnt", gnt_o, eg);
    chk("psel", psel, busy && age >= 1);
    chk("penable", penable, busy && age >= 2);
    chk("paddr", paddr, m_addr);
    chk("pwdata", pwdata, m_wdata);
    chk("pwrite", pwrite, m_we);
    chk("rvalid", rvalid_o, rv_pend ? (one << rv_owner) : '0);
    if (rv_pend) begin
      chk("rdata", rdata_o, rv_data);
      chk("err", err_o, rv_err);
    end
    rv_pend = 0;
    if (busy) begin
      if (age >= 2 && pready) begin
        busy = 0; rv_pend = 1; rv_owner = owner;
        rv_data = m_we ? '0 : prdata; rv_err = pslverr;
      end
`ifdef APB_ARB_TIMEOUT_EN
      else if (age - 1 == TO) begin
        busy = 0; rv_pend = 1; rv_owner = owner; rv_data = '0; rv_err = 1'b1;
      end
`endif
      else age++;
    end else if (w >= 0) begin
      busy = 1; age = 1; owner = w; last_win = w;
      m_addr = addr_i[w*AW +: AW]; m_wdata = wdata_i[w*DW +: DW]; m_we = we_i[w];
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; req_i = '0;
    #1;
    chk("rst_psel", psel, 1'b0);
    chk("rst_penable", penable, 1'b0);
    chk("rst_rvalid", rvalid_o, '0);
    chk("rst_gnt", gnt_o, '0);
    chk("rst_rdata", rdata_o, '0);
    chk("rst_err", err_o, 1'b0);
    chk("rst_paddr", paddr, '0);
    chk("rst_pwdata", pwdata, '0);
    chk("rst_pwrite", pwrite, 1'b0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [NB-1:0] gl [12];
    logic [DW-1:0] pw [12];
    logic [NB-1:0] rv_seen;
    int            cnt;
    bit            pend [NB];

    req_i = '0; we_i = '0; addr_i = '0; wdata_i = '0;
    prdata = '0; pready = 1'b0; pslverr = 1'b0;
    do_reset();

    // Single read from requester 0
    we_i = 2'b00; addr_i[0 +: AW] = 32'h1A10_1000; prdata = 32'hCAFE_0001; pready = 1'b1;
    req_i = 2'b01; tick(); chk("t1_gnt", s_gnt, 2'b01);
    req_i = 2'b00; tick(); chk("t1_setup_psel", s_psel, 1'b1); chk("t1_setup_pen", s_pen, 1'b0);
    tick(); chk("t1_access_pen", s_pen, 1'b1);
    tick(); chk("t1_rvalid", s_rv, 2'b01); chk("t1_rdata", s_rdata, 32'hCAFE_0001);
    chk("t1_err", s_err, 1'b0);

    // Contention with both requesters writing continuously
    do_reset();
    we_i = 2'b11; addr_i = {32'h1A10_3004, 32'h1A10_3000};
    wdata_i = {32'hB1B1_0001, 32'hA0A0_0000}; pready = 1'b1; pslverr = 1'b0;
    req_i = 2'b11;
    for (int k = 0; k < 12; k++) begin
      tick(); gl[k] = s_gnt; pw[k] = s_pwdata;
    end
    req_i = 2'b00; tick();
    chk("t2_gnt0", gl[0], 2'b01); chk("t2_gnt1", gl[3], 2'b10);
    chk("t2_gnt2", gl[6], 2'b01); chk("t2_gnt3", gl[9], 2'b10);
    chk("t2_pwdata0", pw[1], 32'hA0A0_0000); chk("t2_pwdata1", pw[4], 32'hB1B1_0001);
    chk("t2_pwdata2", pw[7], 32'hA0A0_0000); chk("t2_pwdata3", pw[10], 32'hB1B1_0001);

    // Five wait states then a slave error
    we_i = 2'b00; addr_i[AW +: AW] = 32'h1A10_2000; pready = 1'b0; pslverr = 1'b0;
    req_i = 2'b10; tick(); chk("t3_gnt", s_gnt, 2'b10);
    req_i = 2'b00; tick();
    cnt = 0;
    for (int k = 0; k < 5; k++) begin tick(); cnt += int'(s_pen); end
    pready = 1'b1; pslverr = 1'b1; prdata = 32'h0000_1234; tick(); cnt += int'(s_pen);
    pready = 1'b0; pslverr = 1'b0; tick();
    chk("t3_pen_cycles", cnt, 6); chk("t3_rvalid", s_rv, 2'b10); chk("t3_err", s_err, 1'b1);

    // Back-to-back: requester 1 re-requests in its rvalid cycle
    pready = 1'b1; we_i = 2'b10; wdata_i[DW +: DW] = 32'h5555_AAAA;
    req_i = 2'b10; tick();
    req_i = 2'b00; tick(); tick();
    req_i = 2'b10; tick(); chk("t4_rvalid", s_rv, 2'b10); chk("t4_gnt_same", s_gnt, 2'b10);
    req_i = 2'b00; tick(); chk("t4_setup_psel", s_psel, 1'b1); chk("t4_setup_pen", s_pen, 1'b0);
    tick(); tick();

    // Slave that never answers
    we_i = 2'b00; pready = 1'b0; prdata = 32'hDEAD_BEEF;
    req_i = 2'b01; tick(); req_i = 2'b00; tick();
    cnt = 0;
`ifdef APB_ARB_TIMEOUT_EN
    for (int k = 0; k < TO; k++) begin tick(); cnt += int'(s_psel); end
    tick();
    chk("t5_access_cycles", cnt, TO); chk("t5_psel_drop", s_psel, 1'b0);
    chk("t5_rvalid", s_rv, 2'b01); chk("t5_err", s_err, 1'b1); chk("t5_rdata", s_rdata, '0);
`else
    for (int k = 0; k < 1000; k++) begin tick(); cnt += int'(s_psel); end
    chk("t5_psel_held", cnt, 1000);
    pready = 1'b1; tick(); pready = 1'b0; tick();
    chk("t5_rvalid", s_rv, 2'b01);
`endif

    // Reset in the middle of ACCESS
    req_i = 2'b01; pready = 1'b0; tick(); req_i = 2'b00; tick();
    do_reset();
    rv_seen = '0;
    for (int k = 0; k < 3; k++) begin tick(); rv_seen |= s_rv; end
    chk("t6_no_rvalid", rv_seen, '0);
    req_i = 2'b11; tick(); chk("t6_first_gnt", s_gnt, 2'b01);
    req_i = 2'b00; pready = 1'b1; tick(); tick(); tick();

    // Randomized requesters and slave
    for (int i = 0; i < NB; i++) pend[i] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NB; i++) begin
        if (m_gnt[i]) pend[i] = 0;
        if (!pend[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            pend[i] = 1;
            we_i[i] = 1'($urandom_range(0, 1));
            addr_i[i*AW +: AW] = $urandom;
            wdata_i[i*DW +: DW] = $urandom;
          end
        end else if ($urandom_range(0, 15) == 0) begin
          pend[i] = 0;
        end
        req_i[i] = pend[i];
      end
      pready  = 1'($urandom_range(0, 1));
      prdata  = $urandom;
      pslverr = ($urandom_range(0, 3) == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
